// File: rtl/loop_counter.sv
// loop_counter: loadable up/down counter with clamped stepping and a
// terminal-count pulse. Optional macro LOOP_COUNTER_RELOAD_EN keeps the
// counter running and reloads it after each terminal arrival; without it
// the counter parks in DONE holding the terminal value.
module loop_counter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [WIDTH-1:0]  N,
   input  logic              ld_N,
   input  logic              cnt_en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  dout,
   output logic              tc,
   output logic              busy,
   output logic              done
);

   // One extra bit so overshoot past either end is visible.
   localparam int unsigned EW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dout_q,  dout_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             dir_q,   dir_d;
   logic             tc_q,    tc_d;

   logic [EW-1:0]    eff_step;
   logic [EW-1:0]    up_sum;
   logic [EW-1:0]    dn_diff;
   logic             hit;
   logic [WIDTH-1:0] next_cnt;
`ifdef LOOP_COUNTER_RELOAD_EN
   logic [WIDTH-1:0] term;
`endif

   // State register with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         dout_q  <= '0;
         limit_q <= '0;
         dir_q   <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         limit_q <= limit_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
      end
   end

   // Clamped step toward the terminal value.
   always_comb begin
      eff_step = (step == '0) ? EW'(1) : EW'(step);
      up_sum   = {1'b0, dout_q} + eff_step;
      dn_diff  = {1'b0, dout_q} - eff_step;
      if (dir_q) begin
         hit      = (up_sum >= {1'b0, limit_q});
         next_cnt = hit ? limit_q : up_sum[WIDTH-1:0];
      end else begin
         hit      = dn_diff[WIDTH] || (dn_diff == '0);
         next_cnt = hit ? '0 : dn_diff[WIDTH-1:0];
      end
   end

   // Next-state: load beats count beats hold.
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      limit_d = limit_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
`ifdef LOOP_COUNTER_RELOAD_EN
      term    = dir_q ? limit_q : '0;
`endif
      if (ld_N) begin
         limit_d = N;
         dir_d   = up;
         if (N == '0) begin
            dout_d  = '0;
            state_d = DONE;
            tc_d    = 1'b1;
         end else begin
            dout_d  = up ? '0 : N;
            state_d = RUN;
         end
      end else if (cnt_en && (state_q == RUN)) begin
`ifdef LOOP_COUNTER_RELOAD_EN
         if (dout_q == term) begin
            dout_d = dir_q ? '0 : limit_q;
         end else begin
            dout_d = next_cnt;
            tc_d   = hit;
         end
`else
         dout_d = next_cnt;
         if (hit) begin
            tc_d    = 1'b1;
            state_d = DONE;
         end
`endif
      end
   end

   assign dout = dout_q;
   assign tc   = tc_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
